keypad_entry_ctl: RTL and testbench

Keypad entry controller that sequences the keypad scanner's raw output into an edited 4-digit number. It qualifies each key press, applies digit, backspace, clear and enter actions to a 4-digit buffer, and reports committed entries. It sits between `keypad_scan` and `scan_ctl`: `key`/`pressed` come in, and `digit0..digit3` go out as `scan_ctl` inputs `in0..in3`. It runs on the debounce clock.

---
 rtl/keypad_entry_ctl.sv | 199 +++++++++++++++++++
 tb/tb_keypad_entry_ctl.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/keypad_entry_ctl.sv
// keypad_entry_ctl
// Debounces raw keypad scanner output and edits a 4-digit BCD entry buffer.
// Keys 0-9 shift a digit in, A clears, B backspaces, E commits the entry;
// C, D and F are debounced but otherwise ignored.
// Optional feature macro: KEYPAD_AUTOREPEAT_EN (held digit/backspace keys
// repeat after REPEAT_DELAY cycles, then every REPEAT_PERIOD cycles).
module keypad_entry_ctl #(
    parameter int DEBOUNCE_SAMPLES = 4,
    parameter int REPEAT_DELAY     = 8,
    parameter int REPEAT_PERIOD    = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  key,
    input  logic        pressed,
    output logic [3:0]  digit0,
    output logic [3:0]  digit1,
    output logic [3:0]  digit2,
    output logic [3:0]  digit3,
    output logic [2:0]  digit_cnt,
    output logic [15:0] entry_value,
    output logic        entry_valid,
    output logic        overflow
);

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_DEBOUNCE = 2'd1;
    localparam logic [1:0] ST_HELD     = 2'd2;
    localparam logic [1:0] ST_RELEASE  = 2'd3;

    localparam logic [3:0] CNT_LIMIT = 4'(DEBOUNCE_SAMPLES);
    localparam logic [3:0] KEY_CLEAR = 4'hA;
    localparam logic [3:0] KEY_BACK  = 4'hB;
    localparam logic [3:0] KEY_ENTER = 4'hE;
    localparam logic [3:0] BLANK     = 4'hF;

    // Reject illegal parameterisations at elaboration time
    if (DEBOUNCE_SAMPLES < 2 || DEBOUNCE_SAMPLES > 15) begin : g_bad_debounce
        $error("keypad_entry_ctl: DEBOUNCE_SAMPLES must be 2..15");
    end
    if (REPEAT_DELAY < 1 || REPEAT_DELAY > 255 ||
        REPEAT_PERIOD < 1 || REPEAT_PERIOD > 255) begin : g_bad_repeat
        $error("keypad_entry_ctl: REPEAT_DELAY/REPEAT_PERIOD must be 1..255");
    end

    logic [1:0] state;
    logic [3:0] kq;
    logic [3:0] cnt;
    logic       press_commit;
    logic       repeat_fire;
    logic       commit;

    // Blank positions contribute zero to the committed BCD value
    function automatic logic [3:0] blank_to_zero(input logic [3:0] d);
        return (d == BLANK) ? 4'h0 : d;
    endfunction

    // A press is accepted on the sample that brings the match count to the limit
    always_comb begin
        press_commit = (state == ST_DEBOUNCE) && pressed && (key == kq) &&
                       ((cnt + 4'd1) == CNT_LIMIT);
    end

`ifdef KEYPAD_AUTOREPEAT_EN
    logic [7:0] rep_cnt;
    logic       rep_first;
    logic       repeatable;

    // Only digit and backspace keys repeat; the first gap is longer than the rest
    always_comb begin
        repeatable  = (kq <= 4'd9) || (kq == KEY_BACK);
        repeat_fire = (state == ST_HELD) && pressed && repeatable &&
                      ((rep_cnt + 8'd1) ==
                       (rep_first ? 8'(REPEAT_DELAY) : 8'(REPEAT_PERIOD)));
    end

    // Held-cycle counter restarts every time HELD is (re)entered
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rep_cnt   <= 8'd0;
            rep_first <= 1'b1;
        end else if (state != ST_HELD || !pressed) begin
            rep_cnt   <= 8'd0;
            rep_first <= 1'b1;
        end else if (repeat_fire) begin
            rep_cnt   <= 8'd0;
            rep_first <= 1'b0;
        end else begin
            rep_cnt   <= rep_cnt + 8'd1;
        end
    end
`else
    assign repeat_fire = 1'b0;
`endif

    assign commit = press_commit || repeat_fire;

    // Press/release debounce sequencer; actions are decided separately
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            kq    <= 4'h0;
            cnt   <= 4'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pressed) begin
                        kq    <= key;
                        cnt   <= 4'd1;
                        state <= ST_DEBOUNCE;
                    end
                end
                ST_DEBOUNCE: begin
                    if (pressed && key == kq) begin
                        if ((cnt + 4'd1) == CNT_LIMIT) begin
                            state <= ST_HELD;
                        end else begin
                            cnt <= cnt + 4'd1;
                        end
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_HELD: begin
                    if (!pressed) begin
                        cnt   <= 4'd1;
                        state <= ST_RELEASE;
                    end
                end
                ST_RELEASE: begin
                    if (pressed) begin
                        state <= ST_HELD;
                    end else if ((cnt + 4'd1) == CNT_LIMIT) begin
                        state <= ST_IDLE;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Entry buffer editing and the one-cycle status pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            digit0      <= BLANK;
            digit1      <= BLANK;
            digit2      <= BLANK;
            digit3      <= BLANK;
            digit_cnt   <= 3'd0;
            entry_value <= 16'h0000;
            entry_valid <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            entry_valid <= 1'b0;
            overflow    <= 1'b0;
            if (commit) begin
                if (kq <= 4'd9) begin
                    if (digit_cnt < 3'd4) begin
                        digit3    <= digit2;
                        digit2    <= digit1;
                        digit1    <= digit0;
                        digit0    <= kq;
                        digit_cnt <= digit_cnt + 3'd1;
                    end else begin
                        overflow  <= 1'b1;
                    end
                end else if (kq == KEY_BACK) begin
                    if (digit_cnt != 3'd0) begin
                        digit0    <= digit1;
                        digit1    <= digit2;
                        digit2    <= digit3;
                        digit3    <= BLANK;
                        digit_cnt <= digit_cnt - 3'd1;
                    end
                end else if (kq == KEY_CLEAR) begin
                    digit0    <= BLANK;
                    digit1    <= BLANK;
                    digit2    <= BLANK;
                    digit3    <= BLANK;
                    digit_cnt <= 3'd0;
                end else if (kq == KEY_ENTER) begin
                    if (digit_cnt != 3'd0) begin
                        entry_value <= {blank_to_zero(digit3), blank_to_zero(digit2),
                                        blank_to_zero(digit1), blank_to_zero(digit0)};
                        entry_valid <= 1'b1;
                        digit0      <= BLANK;
                        digit1      <= BLANK;
                        digit2      <= BLANK;
                        digit3      <= BLANK;
                        digit_cnt   <= 3'd0;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_keypad_entry_ctl.sv
// tb_keypad_entry_ctl
// Drives keypad_entry_ctl with directed press scenarios and random press/release
// segments, comparing every output each cycle against a press-level model.
module tb_keypad_entry_ctl;

    localparam int D = 4;

    logic        clk;
    logic        rst;
    logic [3:0]  key;
    logic        pressed;
    logic [3:0]  digit0;
    logic [3:0]  digit1;
    logic [3:0]  digit2;
    logic [3:0]  digit3;
    logic [2:0]  digit_cnt;
    logic [15:0] entry_value;
    logic        entry_valid;
    logic        overflow;

    int vectors_applied = 0;
    int miscompares     = 0;

    // Reference model: entered digits oldest-first, last committed value,
    // pending pulses, and whether the next press can be accepted.
    int unsigned model_q[$];
    logic [15:0] model_value;
    logic        model_valid;
    logic        model_ovf;
    bit          armed;

    keypad_entry_ctl #(
        .DEBOUNCE_SAMPLES(D),
        .REPEAT_DELAY(8),
        .REPEAT_PERIOD(3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .key(key),
        .pressed(pressed),
        .digit0(digit0),
        .digit1(digit1),
        .digit2(digit2),
        .digit3(digit3),
        .digit_cnt(digit_cnt),
        .entry_value(entry_value),
        .entry_valid(entry_valid),
        .overflow(overflow)
    );

    // Free-running debounce clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [15:0] got, input logic [15:0] exp);
        vectors_applied++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic modelReset();
        model_q.delete();
        model_value = 16'h0000;
        model_valid = 1'b0;
        model_ovf   = 1'b0;
        armed       = 1'b1;
    endtask

    task automatic modelAction(input logic [3:0] k);
        logic [15:0] v;
        if (k <= 4'd9) begin
            if (model_q.size() < 4) model_q.push_back(int'(k));
            else model_ovf = 1'b1;
        end else if (k == 4'hB) begin
            if (model_q.size() > 0) void'(model_q.pop_back());
        end else if (k == 4'hA) begin
            model_q.delete();
        end else if (k == 4'hE) begin
            if (model_q.size() > 0) begin
                v = 16'h0000;
                foreach (model_q[i]) v = (v << 4) | 16'(model_q[i]);
                model_value = v;
                model_valid = 1'b1;
                model_q.delete();
            end
        end
    endtask

    task automatic compareAll();
        logic [3:0] exp_d [4];
        int idx;
        for (int i = 0; i < 4; i++) begin
            idx = model_q.size() - 1 - i;
            exp_d[i] = (idx >= 0) ? 4'(model_q[idx]) : 4'hF;
        end
        checkOutput("digit0", 16'(digit0), 16'(exp_d[0]));
        checkOutput("digit1", 16'(digit1), 16'(exp_d[1]));
        checkOutput("digit2", 16'(digit2), 16'(exp_d[2]));
        checkOutput("digit3", 16'(digit3), 16'(exp_d[3]));
        checkOutput("digit_cnt", 16'(digit_cnt), 16'(model_q.size()));
        checkOutput("entry_value", entry_value, model_value);
        checkOutput("entry_valid", 16'(entry_valid), 16'(model_valid));
        checkOutput("overflow", 16'(overflow), 16'(model_ovf));
    endtask

    // One sample: drive away from the edge, let the DUT sample, then compare
    task automatic applyStimulus(input logic [3:0] k, input logic p, input bit commit);
        @(negedge clk);
        key     = k;
        pressed = p;
        @(posedge clk);
        #1;
        model_valid = 1'b0;
        model_ovf   = 1'b0;
        if (commit) modelAction(k);
        compareAll();
    endtask

    // A press of `hold` samples followed by `rel` released samples. A press is
    // accepted only when armed and held for D samples, committing on its D-th
    // sample; re-arming needs D consecutive released samples.
    task automatic runPress(input logic [3:0] k, input int hold, input int rel);
        bit c;
        for (int i = 0; i < hold; i++) begin
            c = armed && (i == D - 1);
            applyStimulus(k, 1'b1, c);
            if (c) armed = 1'b0;
        end
        for (int j = 0; j < rel; j++) begin
            applyStimulus(k, 1'b0, 1'b0);
            if (!armed && j == D - 1) armed = 1'b1;
        end
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_d0"}, 16'(digit0), 16'hF);
        checkOutput({tag, "_d3"}, 16'(digit3), 16'hF);
        checkOutput({tag, "_cnt"}, 16'(digit_cnt), 16'h0);
        checkOutput({tag, "_value"}, entry_value, 16'h0000);
        checkOutput({tag, "_valid"}, 16'(entry_valid), 16'h0);
        checkOutput({tag, "_ovf"}, 16'(overflow), 16'h0);
    endtask

    function automatic logic [3:0] randomKey();
        int r;
        r = $urandom_range(0, 19);
        if (r <= 11) return 4'($urandom_range(0, 9));
        if (r <= 13) return 4'hB;
        if (r == 14) return 4'hA;
        if (r <= 16) return 4'hE;
        if (r == 17) return 4'hC;
        if (r == 18) return 4'hD;
        return 4'hF;
    endfunction

    initial begin
        rst     = 1'b1;
        key     = 4'h0;
        pressed = 1'b0;
        modelReset();
        repeat (3) @(posedge clk);
        #1;
        checkResetValues("reset");
        rst = 1'b0;

        // Basic entry: 1, 2, 3
        runPress(4'h1, 6, 6);
        runPress(4'h2, 6, 6);
        runPress(4'h3, 6, 6);

        // Glitch press, then a held press with a short release bounce
        runPress(4'h5, 3, 4);
        runPress(4'h5, 6, 2);
        runPress(4'h5, 3, 6);

        // Overflow and backspace
        runPress(4'hA, 5, 5);
        runPress(4'h9, 5, 5);
        runPress(4'h8, 5, 5);
        runPress(4'h7, 5, 5);
        runPress(4'h6, 5, 5);
        runPress(4'h5, 5, 5);
        for (int i = 0; i < 5; i++) runPress(4'hB, 5, 5);

        // Enter with digits, then enter on an empty buffer
        runPress(4'h4, 5, 5);
        runPress(4'h2, 5, 5);
        runPress(4'hE, 5, 5);
        runPress(4'hE, 5, 5);

        // Reset mid-debounce with buffer 0012, key 7 still held afterwards
        runPress(4'h1, 5, 5);
        runPress(4'h2, 5, 5);
        applyStimulus(4'h7, 1'b1, 1'b0);
        applyStimulus(4'h7, 1'b1, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        modelReset();
        checkResetValues("mid_reset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        runPress(4'h7, 6, 6);

        // Random press/release segments, including glitches and bounces
        for (int n = 0; n < 200; n++) begin
            runPress(randomKey(), $urandom_range(1, 8), $urandom_range(1, 7));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
        $finish;
    end

endmodule
